// File: rtl/i2c_page_buf.sv
// Page buffer and command sequencer feeding the I2C page read/write engine.
// Optional watchdog: define I2C_PAGE_TIMEOUT_EN to enable the timeout/err path.
module i2c_page_buf #(
  parameter int unsigned PAGE_LEN    = 64,
  parameter int unsigned AW          = 6,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [7:0]    host_wdata,
  input  logic [AW-1:0] host_raddr,
  output logic [7:0]    host_rdata,
  input  logic          cmd_start,
  input  logic          cmd_rd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   byte_cnt,
  output logic          eng_wr,
  output logic          eng_rd,
  inout  logic [7:0]    eng_data,
  input  logic          eng_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_XFER, S_STOPW, S_FIN, S_ERR
  } state_t;

  localparam logic [AW-1:0] PTR_MAX  = AW'(PAGE_LEN - 1);
  localparam logic [AW:0]   CNT_LAST = (AW+1)'(PAGE_LEN - 1);

  state_t        state, nxt;
  logic [7:0]    pbuf [PAGE_LEN];
  logic          mode;
  logic [AW-1:0] ptr;
  logic          cap_pend;
  logic          ack_q;
  logic          ack_rise;
  logic          accept;
  logic          step;
  logic          last_step;
  logic          tmo;

  assign ack_rise  = eng_ack & ~ack_q;
  assign accept    = (state == S_IDLE) && cmd_start;
  // Write mode advances on the ack itself; read mode advances on the capture cycle after it.
  assign step      = (state == S_XFER) && (mode ? cap_pend : ack_rise);
  assign last_step = step && (byte_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (cmd_start) nxt = S_REQ;
      S_REQ:   nxt = S_XFER;
      S_XFER:  if (last_step) nxt = S_STOPW;
      S_STOPW: if (ack_rise) nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (tmo) nxt = S_ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= 1'b0;
      ptr      <= '0;
      byte_cnt <= '0;
      cap_pend <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q    <= eng_ack;
      cap_pend <= (state == S_XFER) && mode && ack_rise;
      if (accept) begin
        mode     <= cmd_rd;
        ptr      <= '0;
        byte_cnt <= '0;
      end else if (step) begin
        if (ptr != PTR_MAX) ptr <= ptr + 1'b1;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Buffer storage is deliberately unreset so a reset mid-read keeps captured bytes.
  always_ff @(posedge clk) begin
    if (host_we && !busy) pbuf[host_waddr] <= host_wdata;
    if ((state == S_XFER) && mode && cap_pend) pbuf[ptr] <= eng_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_rdata <= '0;
    else        host_rdata <= pbuf[host_raddr];
  end

`ifdef I2C_PAGE_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_cnt <= '0;
    else if ((state == S_REQ) || ack_rise)
      wd_cnt <= '0;
    else if (((state == S_XFER) || (state == S_STOPW)) && (wd_cnt != WDW'(TIMEOUT_CYC)))
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign tmo = ((state == S_XFER) || (state == S_STOPW)) && (wd_cnt == WDW'(TIMEOUT_CYC));
  assign err = (state == S_ERR);
`else
  // TIMEOUT_CYC stays on the interface so both builds share one parameter list.
  assign tmo = (TIMEOUT_CYC == 0) && 1'b0;
  assign err = 1'b0;
`endif

  assign busy     = (state == S_REQ) || (state == S_XFER) || (state == S_STOPW);
  assign done     = (state == S_FIN);
  assign eng_wr   = (state == S_REQ) && !mode;
  assign eng_rd   = (state == S_REQ) && mode;
  assign eng_data = (!mode && ((state == S_REQ) || (state == S_XFER))) ? pbuf[ptr] : 'z;

endmodule

// File: doc/i2c_page_buf.md
# i2c_page_buf

Page buffer and command sequencer that sits directly upstream of the I2C page read/write engine. Host logic loads up to `PAGE_LEN` bytes into an internal buffer and issues a single start command. The block then pulses the engine's write or read request, presents write bytes on, or captures read bytes from, the engine's shared 8-bit data bus, paced by the engine's `ack` pulses. It signals completion after the engine's stop acknowledge.

## Interface
Parameters:
- `PAGE_LEN`, 64: bytes per transaction; must match the engine's page count; range 1..64.
- `AW`, 6: buffer address width; 2^AW ≥ PAGE_LEN.
- `TIMEOUT_CYC`, 4096: watchdog limit in clk cycles; used only with `I2C_PAGE_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, same clock as the engine.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_we` in 1: buffer write strobe; ignored while `busy`.
- `host_waddr` in AW: buffer write address.
- `host_wdata` in 8: buffer write data.
- `host_raddr` in AW: buffer read address.
- `host_rdata` out 8: registered buffer read data, 1-cycle latency.
- `cmd_start` in 1: single-cycle start pulse; ignored while `busy`.
- `cmd_rd` in 1: sampled with `cmd_start`; 1 = page read, 0 = page write.
- `busy` out 1: high from the cycle after an accepted `cmd_start` until `done`/`err` is asserted.
- `done` out 1: single-cycle completion pulse.
- `err` out 1: single-cycle timeout pulse; tied 0 without the macro.
- `byte_cnt` out AW+1: bytes acknowledged in the current or last transaction.
- `eng_wr` out 1: engine write request.
- `eng_rd` out 1: engine read request.
- `eng_data` inout 8: engine data bus.
- `eng_ack` in 1: engine acknowledge.

## Operation
- Buffer: PAGE_LEN×8 register array, not reset. Host writes land at the clk edge. `host_rdata` registers `buf[host_raddr]` every cycle, including while `busy`.
- Ack edge detect: `ack_q` registers `eng_ack`; `ack_rise = eng_ack & ~ack_q`. Only rising edges count.
- FSM states:
  - IDLE: on `cmd_start`, latch `mode = cmd_rd`, clear `ptr` and `byte_cnt`, go to REQ.
  - REQ: assert `eng_wr` (mode 0) or `eng_rd` (mode 1) for exactly 1 cycle, then go to XFER.
  - XFER, write mode: drive `eng_data = buf[ptr]`. On each `ack_rise`, `ptr++` and `byte_cnt++`. When `byte_cnt` reaches PAGE_LEN, go to STOPW.
  - XFER, read mode: on `ack_rise`, arm capture. On the next cycle, write `eng_data` into `buf[ptr]`, then `ptr++` and `byte_cnt++`. After the PAGE_LEN-th capture, go to STOPW.
  - STOPW: wait for the next `ack_rise`, which is the engine's stop acknowledge, then go to FIN.
  - FIN: pulse `done` for 1 cycle, deassert `busy`, return to IDLE.
- `eng_data` drive rule: driven only when mode = 0 and state is REQ or XFER; high-Z in all other cases. The block never drives the bus in read mode.
- Arithmetic: `ptr` saturates at PAGE_LEN−1 and never wraps. `byte_cnt` is AW+1 bits, so it represents PAGE_LEN exactly.
- Simultaneous events: `cmd_start` together with `host_we` in IDLE is accepted, and the host write completes first (same edge). `ack_rise` in REQ is ignored.

## Timing
- Reset values: `busy`, `done`, `err`, `eng_wr`, `eng_rd` = 0; `byte_cnt` = 0; `host_rdata` = 0; `eng_data` = Z; FSM = IDLE.
- `cmd_start` at cycle N → `eng_wr`/`eng_rd` high at N+1 (REQ) → XFER at N+2.
- Write data for byte k is stable on `eng_data` from entry to XFER, or from the cycle after ack k−1, until ack k.
- Read capture happens 1 cycle after `ack_rise`, when the engine has `link_data` asserted.
- `done` is asserted 1 cycle after the stop `ack_rise`. `busy` falls in the same cycle `done` is high.
- Reset mid-transaction: FSM returns to IDLE immediately and the bus goes high-Z. Buffer contents are retained; partially captured read data stays in the buffer.

## Configuration
- Macro: `I2C_PAGE_TIMEOUT_EN`.
- Defined: a cycle counter clears on every `ack_rise` and on entry to REQ. If it reaches `TIMEOUT_CYC` in XFER or STOPW, the block pulses `err` for 1 cycle, deasserts `busy`, returns to IDLE, and does not pulse `done`. `byte_cnt` holds the partial count.
- Undefined: no counter is built, `err` = 0, and the FSM waits indefinitely.

## Test plan
- Write page: load `buf[i] = i+0x10` for i = 0..63; `cmd_start`, `cmd_rd = 0` → `eng_wr` is a 1-cycle pulse. `eng_data` shows 0x10, 0x11, …, 0x4F, advancing on each ack. After the 65th ack, `done` pulses and `byte_cnt` = 64.
- Read page: `cmd_rd = 1`; the engine model returns 0xFF−i with an ack per byte → `eng_data` is never driven. `host_rdata` at addr 5 reads 0xFA after `done`.
- Busy lockout: `host_we` to addr 0 with 0xAA and a second `cmd_start` while `busy` → both are ignored, and `buf[0]` keeps its original value.
- Reset at byte 20 of a write: `rst_n` low for 2 cycles → `busy` = 0, `eng_data` = Z. A new write then starts from byte 0.
- With `I2C_PAGE_TIMEOUT_EN` and `TIMEOUT_CYC` = 100: stop acks after byte 3 → `err` pulses 100 cycles after the last ack, `done` never pulses, and `byte_cnt` = 3.
